// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and constants for the S-box scheduler
package aes_pkg;

    localparam int SBOX_LANES = 4;
    localparam int ST_BEATS   = 4;

    typedef enum logic [2:0] {
        IDLE,
        ST_RUN,
        ST_DONE,
        KW_RUN,
        KW_DONE
    } sched_state_t;

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - single-byte AES forward S-box lookup
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    // Entry for input 0x00 sits in the top byte, 0xff in the bottom byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] idx;

    assign idx  = {~din, 3'b000};
    assign dout = SBOX_TABLE[idx +: 8];

endmodule

// File: rtl/aes_sbox_sched.sv
// rtl/aes_sbox_sched.sv - shares four S-box lanes between SubBytes and SubWord requesters
module aes_sbox_sched
    import aes_pkg::*;
#(
    parameter logic FIRST_GRANT = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st_req_valid,
    output logic         st_req_ready,
    input  logic [127:0] st_req_data,
    output logic         st_rsp_valid,
    input  logic         st_rsp_ready,
    output logic [127:0] st_rsp_data,
    input  logic         kw_req_valid,
    output logic         kw_req_ready,
    input  logic [31:0]  kw_req_data,
    output logic         kw_rsp_valid,
    input  logic         kw_rsp_ready,
    output logic [31:0]  kw_rsp_data,
    output logic         busy
);

    localparam logic [1:0] LAST_BEAT = 2'(ST_BEATS - 1);

    sched_state_t state, state_nx;
    logic [1:0]   beat;
    logic         prio;
    logic         grant_st, grant_kw;
    logic [127:0] st_in, st_res;
    logic [31:0]  kw_in, kw_res;
    logic [8*SBOX_LANES-1:0] lane_in, lane_out;

    for (genvar g = 0; g < SBOX_LANES; g++) begin : g_lane
        aes_sbox u_sbox (
            .din  (lane_in[8*g +: 8]),
            .dout (lane_out[8*g +: 8])
        );
    end

    assign lane_in = (state == ST_RUN) ? st_in[{beat, 5'd0} +: 32] : kw_in;

    // prio = 0 favours the state requester, 1 favours the key requester.
    always_comb begin
        state_nx = state;
        grant_st = 1'b0;
        grant_kw = 1'b0;
        case (state)
            IDLE: begin
                if (rst_n) begin
                    if (st_req_valid && (!kw_req_valid || !prio)) begin
                        grant_st = 1'b1;
                        state_nx = ST_RUN;
                    end else if (kw_req_valid) begin
                        grant_kw = 1'b1;
                        state_nx = KW_RUN;
                    end
                end
            end
            ST_RUN:  if (beat == LAST_BEAT) state_nx = ST_DONE;
            ST_DONE: if (st_rsp_ready) state_nx = IDLE;
            KW_RUN:  state_nx = KW_DONE;
            KW_DONE: if (kw_rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            beat   <= 2'd0;
            prio   <= FIRST_GRANT;
            st_in  <= '0;
            st_res <= '0;
            kw_in  <= '0;
            kw_res <= '0;
        end else begin
            state <= state_nx;
            if (grant_st) begin
                st_in <= st_req_data;
                beat  <= 2'd0;
                prio  <= 1'b1;
            end
            if (grant_kw) begin
                kw_in <= kw_req_data;
                prio  <= 1'b0;
            end
            // Leaving ST_RUN after the last beat parks the counter at 0 for the next job.
            if (state == ST_RUN) begin
                st_res[{beat, 5'd0} +: 32] <= lane_out;
                beat <= (beat == LAST_BEAT) ? 2'd0 : beat + 2'd1;
            end
            if (state == KW_RUN) kw_res <= lane_out;
        end
    end

    assign st_req_ready = grant_st;
    assign kw_req_ready = grant_kw;
    assign st_rsp_valid = (state == ST_DONE);
    assign kw_rsp_valid = (state == KW_DONE);
    assign st_rsp_data  = st_res;
    assign kw_rsp_data  = kw_res;
    assign busy         = (state != IDLE);

endmodule
